// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter
//
// Round-robin scheduler that shares one sign-magnitude fixed-point multiplier
// (Q fractional bits, N-bit words, MSB = sign) among NUM_REQ requesters.
// One product is issued at most every three cycles: accept (IDLE),
// multiply (MUL), present the response (RESP).
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_req_valid   per-requester request valid             [NUM_REQ]
//   i_req_a       multiplicands, requester k at [k*N +: N] [NUM_REQ*N]
//   i_req_b       multipliers, same packing                [NUM_REQ*N]
//   o_req_ready   one-hot grant/accept, zero when busy     [NUM_REQ]
//   o_rsp_valid   response valid
//   o_rsp_id      owner of the response                    [ID_W]
//   o_rsp_result  sign-magnitude product                   [N]
//   o_rsp_ovr     product magnitude overflowed
//   i_rsp_ready   consumer accepts the response
//
// Build option:
//   FP_MUL_ARB_SAT_EN  when defined, an overflowing product saturates to
//                      {sign, all ones}; otherwise the truncated bits pass.

module fp_mul_arbiter #(
  parameter int Q       = 7,
  parameter int N       = 16,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [NUM_REQ*N-1:0] i_req_a,
  input  logic [NUM_REQ*N-1:0] i_req_b,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic                 o_rsp_valid,
  output logic [ID_W-1:0]      o_rsp_id,
  output logic [N-1:0]         o_rsp_result,
  output logic                 o_rsp_ovr,
  input  logic                 i_rsp_ready
);

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   ptr_reg;
  logic [N-1:0]      a_reg, b_reg;
  logic [N-1:0]      result_reg;
  logic              ovr_reg;
  logic [ID_W-1:0]   rsp_id_reg;

  // Unpack the flat operand buses so the winner can be indexed directly.
  logic [N-1:0] req_a_arr [NUM_REQ];
  logic [N-1:0] req_b_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_a_arr[gi] = i_req_a[gi*N +: N];
      assign req_b_arr[gi] = i_req_b[gi*N +: N];
    end
  endgenerate

  // Round-robin search starting just after the last winner. The modulo keeps
  // the wrap correct for non-power-of-two NUM_REQ, so no tag >= NUM_REQ is
  // ever produced.
  logic               grant_found;
  logic [ID_W-1:0]    grant_id;
  logic [NUM_REQ-1:0] grant_onehot;
  int                 arb_idx;

  always_comb begin
    grant_found  = 1'b0;
    grant_id     = '0;
    grant_onehot = '0;
    arb_idx      = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      arb_idx = (int'(ptr_reg) + i) % NUM_REQ;
      if (!grant_found && i_req_valid[arb_idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(arb_idx);
      end
    end
    if (grant_found) begin
      grant_onehot[grant_id] = 1'b1;
    end
  end

  // Grant is only offered in IDLE; it is also masked while reset is held so
  // that every output reads zero during reset.
  assign o_req_ready = (state_reg == IDLE && i_rst_n) ? grant_onehot : '0;

  // Multiplier datapath on the captured operands.
  logic [2*N-3:0] mag;
  logic [N-2:0]   mag_trunc;
  logic           prod_ovr;
  logic           prod_sign;
  logic [N-1:0]   prod_result;
  logic           unused_mag_low;

  assign mag            = {{(N-1){1'b0}}, a_reg[N-2:0]} * {{(N-1){1'b0}}, b_reg[N-2:0]};
  assign mag_trunc      = mag[N-2+Q:Q];
  assign prod_ovr       = |mag[2*N-3:N-1+Q];
  assign prod_sign      = a_reg[N-1] ^ b_reg[N-1];
  // Bits below the binary point are dropped (truncation, no rounding).
  assign unused_mag_low = ^mag[Q-1:0];

`ifdef FP_MUL_ARB_SAT_EN
  assign prod_result = prod_ovr ? {prod_sign, {(N-1){1'b1}}} : {prod_sign, mag_trunc};
`else
  assign prod_result = {prod_sign, mag_trunc};
`endif

  // FSM
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_found) state_next = MUL;
      MUL:     state_next = RESP;
      RESP:    if (i_rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ptr_reg doubles as the id of the operation in flight: it only moves on an
  // accept, so during MUL it still names the requester being served.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_reg    <= ID_W'(NUM_REQ - 1);
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      ovr_reg    <= 1'b0;
      rsp_id_reg <= '0;
    end else begin
      if (state_reg == IDLE && grant_found) begin
        a_reg   <= req_a_arr[grant_id];
        b_reg   <= req_b_arr[grant_id];
        ptr_reg <= grant_id;
      end
      if (state_reg == MUL) begin
        result_reg <= prod_result;
        ovr_reg    <= prod_ovr;
        rsp_id_reg <= ptr_reg;
      end
    end
  end

  assign o_rsp_valid  = (state_reg == RESP);
  assign o_rsp_id     = rsp_id_reg;
  assign o_rsp_result = result_reg;
  assign o_rsp_ovr    = ovr_reg;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Self-checking bench for fp_mul_arbiter: a transaction-level model
// (arithmetic product, round-robin pick, three-phase timing) checked every
// cycle, plus directed vectors with hand-computed literal results.

module tb_fp_mul_arbiter;
  localparam int Q   = 7;
  localparam int N   = 16;
  localparam int NR  = 4;
  localparam int IDW = 2;

`ifdef FP_MUL_ARB_SAT_EN
  localparam logic [15:0] OVR_EXP = 16'h7FFF;
`else
  localparam logic [15:0] OVR_EXP = 16'h0000;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [3:0]  i_req_valid = '0;
  logic [63:0] i_req_a = '0;
  logic [63:0] i_req_b = '0;
  logic        i_rsp_ready = 1'b1;
  logic [3:0]  o_req_ready;
  logic        o_rsp_valid;
  logic [1:0]  o_rsp_id;
  logic [15:0] o_rsp_result;
  logic        o_rsp_ovr;

  int checks = 0;
  int errors = 0;

  fp_mul_arbiter #(.Q(Q), .N(N), .NUM_REQ(NR), .ID_W(IDW)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_valid  (i_req_valid),
    .i_req_a      (i_req_a),
    .i_req_b      (i_req_b),
    .o_req_ready  (o_req_ready),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_id     (o_rsp_id),
    .o_rsp_result (o_rsp_result),
    .o_rsp_ovr    (o_rsp_ovr),
    .i_rsp_ready  (i_rsp_ready)
  );

  initial forever #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Product from plain integer arithmetic: scale down by 2^Q, anything that
  // does not fit in N-1 magnitude bits is an overflow.
  function automatic logic [16:0] model_mul(input logic [15:0] a, input logic [15:0] b);
    int unsigned prod, q;
    logic        ovr;
    logic [14:0] m;
    prod = 32'(a[14:0]) * 32'(b[14:0]);
    q    = prod / (1 << Q);
    ovr  = (q >= 32768);
    m    = 15'(q % 32768);
`ifdef FP_MUL_ARB_SAT_EN
    if (ovr) m = 15'h7FFF;
`endif
    return {ovr, a[15] ^ b[15], m};
  endfunction

  function automatic int winner(input logic [3:0] v, input int p);
    for (int i = 1; i <= NR; i++) begin
      if (v[(p + i) % NR]) return (p + i) % NR;
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < NR; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // m_phase: 0 = can accept, 1 = product being formed, 2 = response shown
  int          m_phase = 0;
  int          m_ptr = NR - 1;
  int          m_pend_id = 0;
  logic [16:0] m_pend = '0;
  int          m_id = 0;
  logic [15:0] m_res = '0;
  logic        m_ovr = 1'b0;
  int          m_win;

  always_comb m_win = winner(i_req_valid, m_ptr);

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_phase <= 0;
      m_ptr   <= NR - 1;
      m_id    <= 0;
      m_res   <= '0;
      m_ovr   <= 1'b0;
    end else begin
      case (m_phase)
        0: if (m_win >= 0) begin
             m_ptr     <= m_win;
             m_pend_id <= m_win;
             m_pend    <= model_mul(i_req_a[m_win*16 +: 16], i_req_b[m_win*16 +: 16]);
             m_phase   <= 1;
           end
        1: begin
             m_ovr   <= m_pend[16];
             m_res   <= m_pend[15:0];
             m_id    <= m_pend_id;
             m_phase <= 2;
           end
        default: if (i_rsp_ready) m_phase <= 0;
      endcase
    end
  end

  // ---------------- per-cycle compare + grant log ----------------
  int   cyc = 0;
  bit   log_en = 1'b0;
  int   gq[$];
  int   cq[$];

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  initial forever begin
    logic [3:0] er;
    @(negedge i_clk);
    if (i_rst_n) begin
      er = (m_phase == 0 && m_win >= 0) ? (4'b0001 << m_win) : 4'b0000;
      chk("cmp_req_ready", 32'(o_req_ready), 32'(er));
      chk("cmp_rsp_valid", 32'(o_rsp_valid), 32'(m_phase == 2));
      chk("cmp_rsp_id", 32'(o_rsp_id), 32'(m_id));
      chk("cmp_rsp_result", 32'(o_rsp_result), 32'(m_res));
      chk("cmp_rsp_ovr", 32'(o_rsp_ovr), 32'(m_ovr));
      if (log_en && o_req_ready != 4'b0000) begin
        gq.push_back(oh_idx(o_req_ready));
        cq.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int k, input logic [15:0] a, input logic [15:0] b);
    i_req_a[k*16 +: 16] = a;
    i_req_b[k*16 +: 16] = b;
    i_req_valid[k] = 1'b1;
  endtask

  task automatic wait_grant(input int k, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge i_clk);
      if (o_req_ready[k]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge i_clk);
      if (o_rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_ready"}, 32'(o_req_ready), 32'h0);
    chk({tag, "_valid"}, 32'(o_rsp_valid), 32'h0);
    chk({tag, "_id"}, 32'(o_rsp_id), 32'h0);
    chk({tag, "_result"}, 32'(o_rsp_result), 32'h0);
    chk({tag, "_ovr"}, 32'(o_rsp_ovr), 32'h0);
  endtask

  task automatic apply_reset();
    @(negedge i_clk);
    #1 i_rst_n = 1'b0;
    #1 check_zero_outputs("rst");
    @(posedge i_clk);
    #2 i_rst_n = 1'b1;
  endtask

  // One isolated request: grant, latency of one cycle after accept, literals.
  task automatic do_single(input int k, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_res, input logic exp_ovr, input string name);
    bit ok;
    set_req(k, a, b);
    i_rsp_ready = 1'b1;
    wait_grant(k, ok);
    chk({name, "_grant"}, 32'(ok), 32'h1);
    @(posedge i_clk);
    #2 i_req_valid[k] = 1'b0;
    if (ok) begin
      @(negedge i_clk);
      chk({name, "_lat_mul"}, 32'(o_rsp_valid), 32'h0);
      @(negedge i_clk);
      chk({name, "_lat_resp"}, 32'(o_rsp_valid), 32'h1);
      chk({name, "_id"}, 32'(o_rsp_id), 32'(k));
      chk({name, "_result"}, 32'(o_rsp_result), 32'(exp_res));
      chk({name, "_ovr"}, 32'(o_rsp_ovr), 32'(exp_ovr));
      @(posedge i_clk);
      #2;
    end
  endtask

  // ---------------- directed sequence ----------------
  int fexp[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    bit          ok;
    logic [1:0]  s_id;
    logic [15:0] s_res;
    logic        s_ovr;

    #2 check_zero_outputs("por");
    #10 i_rst_n = 1'b1;
    @(posedge i_clk);
    #2;

    do_single(0, 16'h00C0, 16'h0100, 16'h0180, 1'b0, "mul_pos");
    do_single(2, 16'h80C0, 16'h0100, 16'h8180, 1'b0, "mul_neg");
    do_single(2, 16'h8000, 16'h0100, 16'h8000, 1'b0, "neg_zero");
    do_single(1, 16'h4000, 16'h0200, OVR_EXP, 1'b1, "ovr");
    do_single(3, 16'h0060, 16'h8040, 16'h8030, 1'b0, "frac");

    // Backpressure: hold RESP for five cycles with req3 waiting.
    set_req(1, 16'h0080, 16'h0080);
    i_rsp_ready = 1'b0;
    wait_grant(1, ok);
    chk("bp_grant", 32'(ok), 32'h1);
    @(posedge i_clk);
    #2 i_req_valid[1] = 1'b0;
    set_req(3, 16'h0100, 16'h0100);
    wait_valid(ok);
    chk("bp_valid", 32'(ok), 32'h1);
    chk("bp_id", 32'(o_rsp_id), 32'h1);
    chk("bp_result", 32'(o_rsp_result), 32'h0080);
    s_id = o_rsp_id;
    s_res = o_rsp_result;
    s_ovr = o_rsp_ovr;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      chk("bp_hold_valid", 32'(o_rsp_valid), 32'h1);
      chk("bp_hold_id", 32'(o_rsp_id), 32'(s_id));
      chk("bp_hold_result", 32'(o_rsp_result), 32'(s_res));
      chk("bp_hold_ovr", 32'(o_rsp_ovr), 32'(s_ovr));
      chk("bp_hold_ready", 32'(o_req_ready), 32'h0);
    end
    @(posedge i_clk);
    #2 i_rsp_ready = 1'b1;
    @(negedge i_clk);
    chk("bp_still_valid", 32'(o_rsp_valid), 32'h1);
    @(negedge i_clk);
    chk("bp_released", 32'(o_rsp_valid), 32'h0);
    chk("bp_next_grant", 32'(o_req_ready), 32'h8);
    @(posedge i_clk);
    #2 i_req_valid[3] = 1'b0;
    wait_valid(ok);
    chk("bp2_valid", 32'(ok), 32'h1);
    chk("bp2_id", 32'(o_rsp_id), 32'h3);
    chk("bp2_result", 32'(o_rsp_result), 32'h0200);
    @(posedge i_clk);
    #2;

    // Fairness: all four valid continuously from reset.
    apply_reset();
    for (int k = 0; k < NR; k++) set_req(k, 16'((k + 1) * 128), 16'h0100);
    log_en = 1'b1;
    repeat (20) @(posedge i_clk);
    #2 i_req_valid = '0;
    log_en = 1'b0;
    repeat (6) @(posedge i_clk);
    #2;
    chk("fair_count", 32'(gq.size() >= 6), 32'h1);
    for (int i = 0; i < 6 && i < gq.size(); i++) chk($sformatf("fair_id%0d", i), 32'(gq[i]), 32'(fexp[i]));
    for (int i = 1; i < 6 && i < cq.size(); i++) chk($sformatf("fair_gap%0d", i), 32'(cq[i] - cq[i-1]), 32'h3);

    // Reset while in MUL: response lost, ptr back to NUM_REQ-1.
    set_req(3, 16'h0100, 16'h0100);
    wait_grant(3, ok);
    chk("rmul_grant", 32'(ok), 32'h1);
    @(posedge i_clk);
    #3 i_rst_n = 1'b0;
    i_req_valid = '0;
    set_req(0, 16'h0080, 16'h0100);
    set_req(3, 16'h0100, 16'h0100);
    #1 check_zero_outputs("rmul");
    @(posedge i_clk);
    #2 i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rmul_first", 32'(o_req_ready), 32'h1);
    @(posedge i_clk);
    #2 i_req_valid[0] = 1'b0;
    wait_grant(3, ok);
    chk("rmul_second", 32'(ok), 32'h1);
    @(posedge i_clk);
    #2 i_req_valid[3] = 1'b0;
    repeat (6) @(posedge i_clk);
    #2;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
